// File: rtl/stream_byte_packer.sv
// stream_byte_packer: packs DATA_WIDTH-bit beats little-endian into words of
// PACK_RATIO lanes. A word is emitted when it fills, when in_last closes it, or
// when the idle timeout expires. Partial words carry a lane-keep mask.
module stream_byte_packer #(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned PACK_RATIO     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                              clk,
   input  logic                              rstn,
   input  logic                              clear,
   input  logic [DATA_WIDTH-1:0]             in_data,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic                              in_last,
   output logic [DATA_WIDTH*PACK_RATIO-1:0]  out_data,
   output logic [PACK_RATIO-1:0]             out_keep,
   output logic                              out_last,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [$clog2(PACK_RATIO+1)-1:0]   pack_count
);

   localparam int unsigned CW = $clog2(PACK_RATIO + 1);
   localparam int unsigned IW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int unsigned OW = DATA_WIDTH * PACK_RATIO;
   localparam logic [CW-1:0] LAST_LANE = CW'(PACK_RATIO - 1);
   localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT_CYCLES);

   logic [OW-1:0]         acc_q;
   logic [CW-1:0]         acc_cnt_q;
   logic [IW-1:0]         idle_q;
   logic [OW-1:0]         out_data_q;
   logic [PACK_RATIO-1:0] out_keep_q;
   logic                  out_last_q;
   logic                  out_valid_q;

   logic [31:0]           acc_idx;
   logic                  out_free;
   logic                  accept;
   logic                  complete;
   logic                  idle_sat;
   logic                  flush;
   logic [OW-1:0]         load_data;
   logic [PACK_RATIO-1:0] load_keep;

   assign acc_idx  = 32'(acc_cnt_q);
   assign out_free = !out_valid_q || out_ready;
   assign in_ready = out_free;
   assign accept   = in_valid && out_free;
   assign complete = accept && (in_last || (acc_cnt_q == LAST_LANE));
   assign idle_sat = (idle_q == IDLE_MAX);
   assign flush    = (TIMEOUT_CYCLES != 0) && idle_sat && (acc_cnt_q != '0)
                     && out_free && !accept;

   // Candidate output word: held lanes, plus the incoming beat when one is
   // accepted; lanes above the fill point are forced to zero so stale
   // accumulator contents from an earlier word never leak out.
   always_comb begin
      load_data = '0;
      load_keep = '0;
      for (int unsigned k = 0; k < PACK_RATIO; k++) begin
         if (k < acc_idx) begin
            load_data[k*DATA_WIDTH +: DATA_WIDTH] = acc_q[k*DATA_WIDTH +: DATA_WIDTH];
            load_keep[k] = 1'b1;
         end else if ((k == acc_idx) && accept) begin
            load_data[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
            load_keep[k] = 1'b1;
         end
      end
   end

   // Accumulator lanes, fill count and idle counter.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc_q     <= '0;
         acc_cnt_q <= '0;
         idle_q    <= '0;
      end else if (clear) begin
         acc_q     <= '0;
         acc_cnt_q <= '0;
         idle_q    <= '0;
      end else begin
         if (complete || flush) begin
            acc_cnt_q <= '0;
         end else if (accept) begin
            for (int unsigned k = 0; k < PACK_RATIO; k++) begin
               if (k == acc_idx) acc_q[k*DATA_WIDTH +: DATA_WIDTH] <= in_data;
            end
            acc_cnt_q <= acc_cnt_q + CW'(1);
         end
         if (accept || (acc_cnt_q == '0) || flush) idle_q <= '0;
         else if (!idle_sat)                         idle_q <= idle_q + IW'(1);
      end
   end

   // Single output register: loads a completed or flushed word, otherwise
   // drains when the consumer takes it; holds its contents while stalled.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else if (clear) begin
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else if (complete || flush) begin
         out_data_q  <= load_data;
         out_keep_q  <= load_keep;
         out_last_q  <= complete && in_last;
         out_valid_q <= 1'b1;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_data   = out_data_q;
   assign out_keep   = out_keep_q;
   assign out_last   = out_last_q;
   assign out_valid  = out_valid_q;
   assign pack_count = acc_cnt_q;

endmodule

// File: tb/tb_stream_byte_packer.sv
// Self-checking bench for stream_byte_packer (8-bit lanes, 4 lanes, timeout 16).
module tb_stream_byte_packer;

   typedef struct {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
   } exp_t;

   logic        clk = 1'b0;
   logic        rstn;
   logic        clear;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        in_last;
   logic [31:0] out_data;
   logic [3:0]  out_keep;
   logic        out_last;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  pack_count;

   int          compared   = 0;
   int          mismatched = 0;
   exp_t        q[$];
   logic [31:0] m_acc = '0;
   int unsigned m_cnt = 0;

   stream_byte_packer #(
      .DATA_WIDTH(8),
      .PACK_RATIO(4),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .rstn(rstn), .clear(clear),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
      .out_valid(out_valid), .out_ready(out_ready), .pack_count(pack_count)
   );

   always #5 clk = ~clk;

   // Drain-side scoreboard: each negedge with valid&ready is one transfer.
   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (rstn && out_valid && out_ready) begin
            compared++;
            if (q.size() == 0) begin
               mismatched++;
               $display("FAIL unexpected_word: got data=%h keep=%b last=%b, required no word",
                        out_data, out_keep, out_last);
            end else begin
               e = q.pop_front();
               if (out_data !== e.d || out_keep !== e.k || out_last !== e.l) begin
                  mismatched++;
                  $display("FAIL word: got data=%h keep=%b last=%b, required data=%h keep=%b last=%b",
                           out_data, out_keep, out_last, e.d, e.k, e.l);
               end
            end
         end
      end
   endtask

   task automatic model_clear();
      m_acc = '0;
      m_cnt = 0;
      q.delete();
   endtask

   // Offer one beat, wait (bounded) for acceptance, then update the model.
   task automatic push(input logic [7:0] d, input logic last);
      int n = 0;
      exp_t e;
      in_data  = d;
      in_last  = last;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         compared++;
         mismatched++;
         $display("FAIL push_timeout: in_ready stayed 0, required 1 for beat %h", d);
         in_valid = 1'b0;
         in_last  = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      m_acc[m_cnt*8 +: 8] = d;
      m_cnt++;
      if (m_cnt == 4 || last) begin
         e.d = m_acc;
         e.k = 4'((1 << m_cnt) - 1);
         e.l = last;
         q.push_back(e);
         m_acc = '0;
         m_cnt = 0;
      end
   endtask

   task automatic test_reset();
      #12;
      compared++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || out_keep !== 4'h0 ||
          out_last !== 1'b0 || pack_count !== 3'd0 || in_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL reset_state: got v=%b d=%h k=%b l=%b pc=%0d rdy=%b, required 0/0/0/0/0/1",
                  out_valid, out_data, out_keep, out_last, pack_count, in_ready);
      end
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_full_word();
      push(8'h11, 1'b0);
      push(8'h22, 1'b0);
      push(8'h33, 1'b0);
      push(8'h44, 1'b0);
      compared++;
      if (out_valid !== 1'b1 || pack_count !== 3'd0 || out_data !== 32'h44332211) begin
         mismatched++;
         $display("FAIL full_word_load: got v=%b pc=%0d d=%h, required 1/0/44332211",
                  out_valid, pack_count, out_data);
      end
      @(posedge clk);
      #1;
      compared++;
      if (out_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL full_word_one_cycle: got out_valid=%b, required 0", out_valid);
      end
   endtask

   task automatic test_last_partial();
      push(8'hA1, 1'b0);
      push(8'hB2, 1'b1);
      compared++;
      if (out_valid !== 1'b1 || out_keep !== 4'b0011 || out_last !== 1'b1 ||
          out_data !== 32'h0000B2A1) begin
         mismatched++;
         $display("FAIL last_partial: got v=%b d=%h k=%b l=%b, required 1/0000b2a1/0011/1",
                  out_valid, out_data, out_keep, out_last);
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_timeout();
      exp_t e;
      push(8'h5C, 1'b0);
      repeat (16) @(posedge clk);
      #1;
      compared++;
      if (out_valid !== 1'b0 || pack_count !== 3'd1) begin
         mismatched++;
         $display("FAIL timeout_early: got v=%b pc=%0d after 16 edges, required 0/1",
                  out_valid, pack_count);
      end
      e.d = m_acc;
      e.k = 4'((1 << m_cnt) - 1);
      e.l = 1'b0;
      q.push_back(e);
      m_acc = '0;
      m_cnt = 0;
      @(posedge clk);
      #1;
      compared++;
      if (out_valid !== 1'b1 || out_data !== 32'h0000005C || out_keep !== 4'b0001 ||
          out_last !== 1'b0 || pack_count !== 3'd0) begin
         mismatched++;
         $display("FAIL timeout_flush: got v=%b d=%h k=%b l=%b pc=%0d, required 1/0000005c/0001/0/0",
                  out_valid, out_data, out_keep, out_last, pack_count);
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      fork
         begin
            for (int i = 1; i <= 8; i++) push(8'(i), 1'b0);
         end
         begin
            repeat (8) @(posedge clk);
            #1;
            compared++;
            if (out_valid !== 1'b1 || out_data !== 32'h04030201 || in_ready !== 1'b0 ||
                pack_count !== 3'd0) begin
               mismatched++;
               $display("FAIL bp_hold: got v=%b d=%h rdy=%b pc=%0d, required 1/04030201/0/0",
                        out_valid, out_data, in_ready, pack_count);
            end
            repeat (3) @(posedge clk);
            #1;
            compared++;
            if (out_data !== 32'h04030201 || out_keep !== 4'b1111 || out_valid !== 1'b1) begin
               mismatched++;
               $display("FAIL bp_stable: got d=%h k=%b v=%b, required 04030201/1111/1",
                        out_data, out_keep, out_valid);
            end
            out_ready = 1'b1;
         end
      join
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_clear();
      push(8'h91, 1'b0);
      push(8'h92, 1'b0);
      push(8'h93, 1'b0);
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      m_acc = '0;
      m_cnt = 0;
      compared++;
      if (pack_count !== 3'd0 || out_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL clear_state: got pc=%0d v=%b, required 0/0", pack_count, out_valid);
      end
      repeat (20) @(posedge clk);
      #1;
      compared++;
      if (out_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL clear_no_flush: got out_valid=%b, required 0", out_valid);
      end
      push(8'hA0, 1'b0);
      push(8'hA1, 1'b0);
      push(8'hA2, 1'b0);
      push(8'hA3, 1'b0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_async_reset();
      // Partial word in the accumulator.
      push(8'h61, 1'b0);
      push(8'h62, 1'b0);
      #2;
      rstn = 1'b0;
      #1;
      compared++;
      if (pack_count !== 3'd0 || in_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL areset_partial: got pc=%0d rdy=%b, required 0/1", pack_count, in_ready);
      end
      model_clear();
      @(posedge clk);
      #3;
      rstn = 1'b1;
      @(posedge clk);
      #1;
      // Completed word stalled in the output register.
      push(8'h71, 1'b0);
      push(8'h72, 1'b0);
      push(8'h73, 1'b0);
      push(8'h74, 1'b0);
      out_ready = 1'b0;
      #1;
      compared++;
      if (out_valid !== 1'b1 || out_data !== 32'h74737271) begin
         mismatched++;
         $display("FAIL areset_pre: got v=%b d=%h, required 1/74737271", out_valid, out_data);
      end
      #1;
      rstn = 1'b0;
      #1;
      compared++;
      if (out_valid !== 1'b0 || out_keep !== 4'h0 || pack_count !== 3'd0 || out_data !== 32'h0) begin
         mismatched++;
         $display("FAIL areset_held: got v=%b k=%b pc=%0d d=%h, required 0/0/0/0",
                  out_valid, out_keep, pack_count, out_data);
      end
      model_clear();
      @(posedge clk);
      #3;
      rstn = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      push(8'h81, 1'b0);
      push(8'h82, 1'b0);
      push(8'h83, 1'b0);
      push(8'h84, 1'b1);
      compared++;
      if (out_valid !== 1'b1 || out_keep !== 4'b1111 || out_last !== 1'b1) begin
         mismatched++;
         $display("FAIL resume_full_last: got v=%b k=%b l=%b, required 1/1111/1",
                  out_valid, out_keep, out_last);
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      rstn      = 1'b0;
      clear     = 1'b0;
      in_data   = '0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      fork
         monitor();
      join_none
      test_reset();
      test_full_word();
      test_last_partial();
      test_timeout();
      test_backpressure();
      test_clear();
      test_async_reset();
      repeat (5) @(posedge clk);
      #1;
      compared++;
      if (q.size() != 0) begin
         mismatched++;
         $display("FAIL scoreboard_drain: got %0d words outstanding, required 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/stream_byte_packer.md
Name: stream_byte_packer

Overview:
Downstream consumer of the interleaved sync FIFO output stream. Accepts DATA_WIDTH-bit beats over valid/ready and packs PACK_RATIO beats into one wide word, little-endian: the first beat goes in lane 0. Emits partial words with a lane-keep mask on an in_last marker or after an idle timeout. Feeds a wide-bus consumer such as a DMA or bus-write stage.

Parameters:
DATA_WIDTH, 8, width of one input beat (one lane)
PACK_RATIO, 4, lanes per output word; must be >= 2
TIMEOUT_CYCLES, 16, idle cycles before a partial word is flushed; 0 disables the timeout

Ports:
clk  in  1  clock, rising edge
rstn  in  1  reset; asynchronous, active-low
clear  in  1  synchronous flush/discard of all state
in_data  in  DATA_WIDTH  input beat
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
in_last  in  1  beat closes the current word (qualified by in_valid)
out_data  out  DATA_WIDTH*PACK_RATIO  packed word; lane k = bits [k*DATA_WIDTH +: DATA_WIDTH]
out_keep  out  PACK_RATIO  lane k holds valid data
out_last  out  1  word was closed by in_last
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts the word
pack_count  out  $clog2(PACK_RATIO+1)  lanes currently held in the accumulator

Behaviour:
- Reset (rstn=0, asynchronous): out_valid=0, out_data=0, out_keep=0, out_last=0, accumulator empty, pack_count=0, idle counter=0. While out_valid=0, in_ready=1.
- clear=1 at a clock edge: same values as reset, applied synchronously. Any held or pending word is discarded. A beat offered in that cycle is dropped. clear takes priority over every other event.
- State: accumulator (lane registers plus acc_cnt) and a single output register (out_*).
- "Output free" = !out_valid || out_ready.
- in_ready = output free. This is combinational from out_ready and is the only combinational input-to-output path.
- Accept = in_valid && in_ready.
- On accept, if acc_cnt+1 == PACK_RATIO or in_last=1:
  - Load the output register with the accumulator lanes plus in_data in lane acc_cnt.
  - out_keep = bits [acc_cnt:0] set; out_last = in_last; out_valid = 1.
  - acc_cnt <= 0.
- On accept otherwise: write in_data to lane acc_cnt; acc_cnt <= acc_cnt+1.
- Latency: a completing beat accepted at edge N gives out_valid=1 after edge N.
- Output hold: out_data, out_keep and out_last are stable while out_valid=1 and out_ready=0.
- Output drain: if out_ready=1 and no new load occurs, out_valid <= 0. If out_ready=1 and a load occurs in the same cycle, the new word replaces the old one back-to-back, at full throughput of one word per PACK_RATIO beats.
- Unused lanes of a partial word read 0; keep bits of unused lanes are 0.
- Idle counter:
  - Cleared on any accept and while acc_cnt == 0.
  - Otherwise increments each cycle, saturating at TIMEOUT_CYCLES.
- Timeout flush: when TIMEOUT_CYCLES != 0, idle == TIMEOUT_CYCLES, acc_cnt > 0, output free and no accept this cycle:
  - Load the output register with the accumulator; out_keep = lanes [acc_cnt-1:0]; out_last = 0.
  - acc_cnt <= 0; idle <= 0.
  - If the output is not free, the flush waits while the counter stays saturated.
- Simultaneous accept and timeout: the accept wins and no flush occurs.
- pack_count = acc_cnt; it never equals PACK_RATIO.
- in_last on a beat that fills lane PACK_RATIO-1: full keep, out_last=1.
- No beat is lost or duplicated under any out_ready pattern.

Test Plan:
1. Reset, then push 0x11, 0x22, 0x33, 0x44 with out_ready=1 -> one word out_data=0x44332211, out_keep=4'b1111, out_last=0, out_valid for exactly 1 cycle, pack_count back to 0.
2. Push 0xA1, then 0xB2 with in_last=1 -> out_data=0x0000B2A1, out_keep=4'b0011, out_last=1.
3. Push 0x5C, then idle with in_valid=0 -> out_valid rises after the 17th edge following the accept, with out_data=0x0000005C, out_keep=4'b0001, out_last=0.
4. Hold out_ready=0 and stream 8 beats 0x01..0x08 -> word 0x04030201 held stable, in_ready=0 once the 4th lane is pending. Raise out_ready -> 0x04030201 then 0x08070605 delivered in order, no loss.
5. Push 3 beats, pulse clear -> pack_count=0, no output word. Then 4 new beats -> only the new word appears.
6. Assert rstn=0 mid-word, asynchronously between edges, with out_valid=1 -> out_valid, out_keep, pack_count drop to 0 immediately. After release, normal packing resumes.
